// File: rtl/serial_tc_pkg.sv
// Shared mode encoding and negate decision for the serial two's-complement converter.
package serial_tc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_RSVD = 2'b11
    } tc_mode_t;

    // Reserved mode falls through to pass-through.
    function automatic logic negate_sel(input tc_mode_t mode, input logic sign);
        return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
    endfunction

endpackage

// File: rtl/serial_tc_if.sv
// Framed serial stream bundle: input bits with word framing, converted output bits with flags.
interface serial_tc_if #(parameter int CHANNELS = 1);
    import serial_tc_pkg::*;

    logic                in_valid;
    logic                in_first;
    logic [CHANNELS-1:0] in_bit;
    tc_mode_t            mode;
    logic                out_valid;
    logic                out_first;
    logic                out_last;
    logic [CHANNELS-1:0] out_bit;
    logic [CHANNELS-1:0] out_ovf;

    modport master (
        output in_valid, in_first, in_bit, mode,
        input  out_valid, out_first, out_last, out_bit, out_ovf
    );

    modport slave (
        input  in_valid, in_first, in_bit, mode,
        output out_valid, out_first, out_last, out_bit, out_ovf
    );

endinterface

// File: rtl/serial_tc_lane.sv
// One lane: capture shift register, output shift register and bit-serial negation.
module serial_tc_lane
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     t_clk,
    input  logic     r_n,
    input  logic     accept,
    input  logic     load,
    input  logic     shift,
    input  logic     last,
    input  tc_mode_t mode_emit,
    input  logic     in_bit,
    output logic     out_bit,
    output logic     out_ovf
);

    // The newest bit arrives on in_bit, so only WIDTH-1 bits need holding.
    logic [WIDTH-2:0] csr;
    logic [WIDTH-1:0] osr;
    logic             sign;
    logic             seen_one;
    logic             neg;

    assign neg = negate_sel(mode_emit, sign);

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            csr      <= '0;
            osr      <= '0;
            sign     <= 1'b0;
            seen_one <= 1'b0;
            out_bit  <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                csr <= (WIDTH-1)'({in_bit, csr} >> 1);
            end

            if (load) begin
                osr      <= {in_bit, csr};
                sign     <= in_bit;
                seen_one <= 1'b0;
            end else if (shift) begin
                osr      <= osr >> 1;
                seen_one <= seen_one | osr[0];
            end

            // Only the most negative value reaches the MSB with no earlier one.
            if (shift) begin
                out_bit <= osr[0] ^ (neg & seen_one);
                out_ovf <= last & neg & ~seen_one & osr[0];
            end else begin
                out_bit <= 1'b0;
                out_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_tc_converter.sv
// Multi-lane framed serial converter: pass, negate or absolute value, LSB first.
module serial_tc_converter
    import serial_tc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1
) (
    input  logic        t_clk,
    input  logic        r_n,
    serial_tc_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0]       cnt;
    logic [CW-1:0]       ecnt;
    logic [CW-1:0]       bit_idx;
    logic                in_prog;
    logic                active;
    logic                accept;
    logic                load;
    logic                last;
    tc_mode_t            mode_cap;
    tc_mode_t            mode_emit;
    logic                out_valid_q;
    logic                out_first_q;
    logic                out_last_q;
    logic [CHANNELS-1:0] lane_bit;
    logic [CHANNELS-1:0] lane_ovf;

    always_comb begin
        accept  = bus.in_valid && (bus.in_first || in_prog);
        bit_idx = bus.in_first ? '0 : cnt;
        load    = accept && (bit_idx == LAST_IDX);
        last    = active && (ecnt == LAST_IDX);
    end

    // A load may coincide with the final emit cycle of the previous word.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            cnt         <= '0;
            ecnt        <= '0;
            in_prog     <= 1'b0;
            active      <= 1'b0;
            mode_cap    <= MODE_PASS;
            mode_emit   <= MODE_PASS;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (bus.in_first) begin
                    mode_cap <= bus.mode;
                end
                if (load) begin
                    cnt     <= '0;
                    in_prog <= 1'b0;
                end else begin
                    cnt     <= bit_idx + CW'(1);
                    in_prog <= 1'b1;
                end
            end

            if (load) begin
                mode_emit <= mode_cap;
                active    <= 1'b1;
                ecnt      <= '0;
            end else if (last) begin
                active <= 1'b0;
                ecnt   <= '0;
            end else if (active) begin
                ecnt <= ecnt + CW'(1);
            end

            out_valid_q <= active;
            out_first_q <= active && (ecnt == '0);
            out_last_q  <= last;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        serial_tc_lane #(.WIDTH(WIDTH)) u_lane (
            .t_clk     (t_clk),
            .r_n       (r_n),
            .accept    (accept),
            .load      (load),
            .shift     (active),
            .last      (last),
            .mode_emit (mode_emit),
            .in_bit    (bus.in_bit[c]),
            .out_bit   (lane_bit[c]),
            .out_ovf   (lane_ovf[c])
        );
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_bit   = lane_bit;
    assign bus.out_ovf   = lane_ovf;

endmodule

// File: tb/tb_serial_tc_converter.sv
// Scoreboard bench for serial_tc_converter, WIDTH=8, CHANNELS=2.
module tb_serial_tc_converter;
    import serial_tc_pkg::*;

    localparam int W  = 8;
    localparam int CH = 2;

    logic t_clk = 1'b0;
    logic r_n   = 1'b0;

    serial_tc_if #(.CHANNELS(CH)) bus();

    serial_tc_converter #(.WIDTH(W), .CHANNELS(CH)) dut (
        .t_clk (t_clk),
        .r_n   (r_n),
        .bus   (bus)
    );

    always #5 t_clk = ~t_clk;

    typedef struct packed {
        logic [15:0] w;
        logic [1:0]  o;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          rd = 0;
    int          obs_cnt = 0;
    int          frame_err = 0;
    int          mon_idx = 0;
    logic [15:0] obs_w[0:63];
    logic [1:0]  obs_o[0:63];
    int          obs_first[0:63];
    int          obs_last[0:63];

    initial forever begin
        @(posedge t_clk);
        cyc++;
    end

    initial begin : monitor
        logic [15:0] cur;
        int          f_cyc;
        cur = '0;
        f_cyc = 0;
        forever begin
            @(negedge t_clk);
            if (!r_n) begin
                mon_idx = 0;
            end else if (bus.out_valid) begin
                if (bus.out_first !== (mon_idx == 0) || bus.out_last !== (mon_idx == W-1) ||
                    (mon_idx != W-1 && bus.out_ovf !== 2'b00)) begin
                    frame_err++;
                    $display("FAIL framing idx=%0d first=%b last=%b ovf=%b", mon_idx,
                             bus.out_first, bus.out_last, bus.out_ovf);
                end
                if (mon_idx == 0) f_cyc = cyc;
                cur[mon_idx]     = bus.out_bit[0];
                cur[W + mon_idx] = bus.out_bit[1];
                if (mon_idx == W-1) begin
                    if (obs_cnt < 64) begin
                        obs_w[obs_cnt]     = cur;
                        obs_o[obs_cnt]     = bus.out_ovf;
                        obs_first[obs_cnt] = f_cyc;
                        obs_last[obs_cnt]  = cyc;
                    end
                    obs_cnt++;
                    mon_idx = 0;
                end else begin
                    mon_idx++;
                end
            end else if (mon_idx != 0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0 ||
                         bus.out_ovf !== 2'b00) begin
                frame_err++;
                $display("FAIL idle_flags idx=%0d first=%b last=%b ovf=%b", mon_idx,
                         bus.out_first, bus.out_last, bus.out_ovf);
                mon_idx = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: arithmetic negate/abs on whole words, {ovf, result}.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [1:0] m);
        logic neg;
        neg = (m == 2'b01) || (m == 2'b10 && x[7]);
        return {neg && (x == 8'h80), neg ? (~x + 8'd1) : x};
    endfunction

    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                             input int stall_at, input int stall_len, input bit push,
                             output int t0);
        logic [8:0] ra, rb;
        exp_t       e;
        t0 = 0;
        if (push) begin
            ra = model(a, m);
            rb = model(b, m);
            e.w = {rb[7:0], ra[7:0]};
            e.o = {rb[8], ra[8]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < W; i++) begin
            bus.in_valid = 1'b1;
            bus.in_first = (i == 0);
            bus.in_bit   = {b[i], a[i]};
            bus.mode     = tc_mode_t'(m);
            if (i == 0) t0 = cyc;
            @(posedge t_clk); #1;
            if (i == stall_at) begin
                bus.in_valid = 1'b0;
                bus.in_first = 1'b0;
                repeat (stall_len) begin
                    @(posedge t_clk); #1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                                input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.in_valid = 1'b1;
            bus.in_first = (i == 0);
            bus.in_bit   = {b[i], a[i]};
            bus.mode     = tc_mode_t'(m);
            @(posedge t_clk); #1;
        end
    endtask

    task automatic wait_words(input int n, output bit to);
        int k;
        k = 0;
        while (obs_cnt < rd + n && k < 300) begin
            @(negedge t_clk); #1;
            k++;
        end
        to = (obs_cnt < rd + n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge t_clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_bit   = '0;
        bus.mode     = MODE_PASS;
        r_n = 1'b0;
        @(posedge t_clk); #1;
        n_vec++;
        if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_bit, bus.out_ovf} !== 7'b0) begin
            n_miss++;
            $display("FAIL reset_state got %b%b%b bit=%b ovf=%b want all 0", bus.out_valid,
                     bus.out_first, bus.out_last, bus.out_bit, bus.out_ovf);
        end
        r_n = 1'b1;
        idle(2);
    endtask

    task automatic test_neg();
        int t0;
        bit to;
        exp_t e;
        send_word(8'h05, 8'h01, 2'b01, -1, 0, 1'b1, t0);
        wait_words(1, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL neg_timeout got %0d words want %0d", obs_cnt, rd+1); end
        n_vec++;
        if (obs_first[rd] - t0 !== 9) begin
            n_miss++;
            $display("FAIL neg_latency got %0d want 9", obs_first[rd] - t0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL neg_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
    endtask

    task automatic test_abs_pass_back_to_back();
        int t0;
        bit to;
        exp_t e;
        int base;
        base = rd;
        send_word(8'hF6, 8'h0A, 2'b10, -1, 0, 1'b1, t0);
        send_word(8'h5A, 8'hA5, 2'b00, -1, 0, 1'b1, t0);
        wait_words(2, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL b2b_timeout got %0d words want %0d", obs_cnt, rd+2); end
        n_vec++;
        if (obs_first[base+1] !== obs_last[base] + 1) begin
            n_miss++;
            $display("FAIL b2b_gap got first=%0d want %0d", obs_first[base+1], obs_last[base] + 1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL b2b_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
    endtask

    task automatic test_overflow();
        int t0;
        bit to;
        exp_t e;
        send_word(8'h80, 8'h00, 2'b01, -1, 0, 1'b1, t0);
        send_word(8'h80, 8'h00, 2'b10, -1, 0, 1'b1, t0);
        wait_words(2, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL ovf_timeout got %0d words want %0d", obs_cnt, rd+2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL ovf_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
    endtask

    task automatic test_stall();
        int t0, t1;
        bit to;
        exp_t e;
        int base;
        base = rd;
        send_word(8'h37, 8'hC9, 2'b01, -1, 0, 1'b1, t0);
        idle(3);
        send_word(8'h37, 8'hC9, 2'b01, 3, 3, 1'b1, t1);
        wait_words(2, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL stall_timeout got %0d words want %0d", obs_cnt, rd+2); end
        n_vec++;
        if (obs_first[base+1] - t1 !== (obs_first[base] - t0) + 3) begin
            n_miss++;
            $display("FAIL stall_latency got %0d want %0d", obs_first[base+1] - t1,
                     (obs_first[base] - t0) + 3);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL stall_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
    endtask

    task automatic test_resync();
        int t0;
        bit to;
        exp_t e;
        send_partial(8'h11, 8'h22, 2'b01, 5);
        send_word(8'h6C, 8'h93, 2'b10, -1, 0, 1'b1, t0);
        wait_words(1, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL resync_timeout got %0d words want %0d", obs_cnt, rd+1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL resync_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
        idle(20);
        n_vec++;
        if (obs_cnt !== rd) begin
            n_miss++;
            $display("FAIL resync_extra got %0d words want %0d", obs_cnt, rd);
        end
    endtask

    task automatic test_reset_mid_emit();
        int t0;
        bit to;
        exp_t e;
        int k;
        send_word(8'h3C, 8'hC3, 2'b01, -1, 0, 1'b0, t0);
        k = 0;
        while (cyc < t0 + 13 && k < 50) begin
            @(posedge t_clk); #1;
            k++;
        end
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_pre_valid got %b want 1", bus.out_valid);
        end
        #2;
        r_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_bit, bus.out_ovf} !== 7'b0) begin
            n_miss++;
            $display("FAIL rst_async got %b%b%b bit=%b ovf=%b want all 0", bus.out_valid,
                     bus.out_first, bus.out_last, bus.out_bit, bus.out_ovf);
        end
        idle(2);
        r_n = 1'b1;
        idle(2);
        send_word(8'h3C, 8'hC3, 2'b01, -1, 0, 1'b1, t0);
        wait_words(1, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL rst_timeout got %0d words want %0d", obs_cnt, rd+1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL rst_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
        idle(20);
        n_vec++;
        if (obs_cnt !== rd) begin
            n_miss++;
            $display("FAIL rst_extra got %0d words want %0d", obs_cnt, rd);
        end
    endtask

    task automatic test_mode11_and_stray();
        int t0;
        bit to;
        exp_t e;
        int seen_valid;
        send_word(8'h3C, 8'h81, 2'b11, -1, 0, 1'b1, t0);
        wait_words(1, to);
        n_vec++;
        if (to) begin n_miss++; $display("FAIL m11_timeout got %0d words want %0d", obs_cnt, rd+1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_w[rd] !== e.w || obs_o[rd] !== e.o) begin
                n_miss++;
                $display("FAIL m11_word got %h/%b want %h/%b", obs_w[rd], obs_o[rd], e.w, e.o);
            end
            rd++;
        end
        idle(12);
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            bus.in_valid = (i < 10);
            bus.in_first = 1'b0;
            bus.in_bit   = 2'($urandom);
            bus.mode     = tc_mode_t'(2'($urandom));
            @(negedge t_clk);
            if (bus.out_valid !== 1'b0) seen_valid++;
            @(posedge t_clk); #1;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (seen_valid !== 0) begin
            n_miss++;
            $display("FAIL stray_valid got %0d valid cycles want 0", seen_valid);
        end
        n_vec++;
        if (obs_cnt !== rd) begin
            n_miss++;
            $display("FAIL stray_words got %0d words want %0d", obs_cnt, rd);
        end
    endtask

    task automatic test_framing_summary();
        n_vec++;
        if (frame_err !== 0) begin
            n_miss++;
            $display("FAIL framing_total got %0d errors want 0", frame_err);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_miss++;
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_neg();
        test_abs_pass_back_to_back();
        test_overflow();
        test_stall();
        test_resync();
        test_reset_mid_emit();
        test_mode11_and_stray();
        test_framing_summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
